// File: rtl/seqdet_pkg.sv
// Shared constants for the frame-level serial pattern detector.
// FSM state codes, default widths and the pattern-length clamp.
package seqdet_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PAT_W_DEF  = 8;
  localparam int CNT_W_DEF  = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Zero length behaves as one bit; anything past the
  // window depth is limited to the window depth.
  function automatic logic [3:0] clamp_len(
    input logic [3:0]  len,
    input int unsigned max_len
  );
    logic [3:0] r;
    r = len;
    if (len == 4'd0)
      r = 4'd1;
    else if ({28'd0, len} > max_len)
      r = max_len[3:0];
    return r;
  endfunction

endpackage

// File: rtl/pattern_window_det.sv
// Bit-serial window with masked pattern compare and bit-seen count.
// Ports: clear/shift_en/bit_in from controller; hit (comb), match (reg).
module pattern_window_det #(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pat,
  input  logic [3:0]       len,
  output logic             hit,
  output logic             match
);
  import seqdet_pkg::*;

  localparam int SW = $clog2(PAT_W + 1);
  localparam logic [SW-1:0] SEEN_MAX = SW'(PAT_W);

  logic [PAT_W-1:0] win;
  logic [PAT_W-1:0] win_nxt;
  logic [PAT_W-1:0] mask;
  logic [SW-1:0]    seen;
  logic [SW-1:0]    seen_nxt;

  assign win_nxt  = {win[PAT_W-2:0], bit_in};
  assign seen_nxt = (seen == SEEN_MAX) ? seen
                                       : seen + SW'(1);
  assign mask     = PAT_W'((33'd1 << len) - 33'd1);

  // Compare against the window as it will be after this shift,
  // so the hit lines up with the edge that stores the bit.
  assign hit = shift_en
            && (((win_nxt ^ pat) & mask) == '0)
            && (32'(seen_nxt) >= 32'(len));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      win   <= '0;
      seen  <= '0;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (shift_en) begin
        win  <= win_nxt;
        seen <= seen_nxt;
      end
    end
  end

endmodule

// File: rtl/seqdet_scan_ctrl.sv
// Frame controller: accepts words, serializes MSB-first, counts matches.
// Ports: start/cfg_*, in_* handshake, busy/done/match_pulse/match_cnt.
module seqdet_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic [3:0]        cfg_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic              match_pulse,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt
);
  import seqdet_pkg::*;

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        state;
  logic [PAT_W-1:0]  pat_q;
  logic [3:0]        len_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic [IW-1:0]     idx;
  logic              clear;
  logic              shift_en;
  logic              bit_in;
  logic              hit;

  assign clear    = (state == S_IDLE) && start;
  assign shift_en = (state == S_SHIFT);
  assign bit_in   = data_q[idx];
  assign in_ready = (state == S_WAIT);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  pattern_window_det #(.PAT_W(PAT_W)) u_det (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .shift_en (shift_en),
    .bit_in   (bit_in),
    .pat      (pat_q),
    .len      (len_q),
    .hit      (hit),
    .match    (match_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pat_q  <= '0;
      len_q  <= 4'd1;
      data_q <= '0;
      last_q <= 1'b0;
      idx    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pat_q <= cfg_pat;
            len_q <= clamp_len(cfg_len, PAT_W);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (in_valid) begin
            data_q <= in_data;
            last_q <= in_last;
            idx    <= IDX_TOP;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          idx <= idx - IW'(1);
          if (idx == '0)
            state <= last_q ? S_DONE : S_WAIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Count lands on the same edge as the shift, so the total is
  // already final in the cycle where done is high.
  always_ff @(posedge clk) begin
    if (rst || clear)
      match_cnt <= '0;
    else if (hit && match_cnt != CNT_MAX)
      match_cnt <= match_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_seqdet_scan_ctrl.sv
// Self-checking bench for seqdet_scan_ctrl with a bit-history model.
// Directed test-plan frames plus randomized frames.
module tb_seqdet_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       busy;
  logic       match_pulse;
  logic       done;
  logic [7:0] match_cnt;

  int checks = 0;
  int passed = 0;
  logic [7:0] wq[$];

  always #5 clk = ~clk;

  seqdet_scan_ctrl #(.DATA_W(8), .PAT_W(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_pat     (cfg_pat),
    .cfg_len     (cfg_len),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .busy        (busy),
    .match_pulse (match_pulse),
    .done        (done),
    .match_cnt   (match_cnt)
  );

  task automatic run_frame(
    input logic [7:0] pat,
    input logic [3:0] len,
    input bit         hold,
    input string      name
  );
    int L;
    bit hist[$];
    int nm;
    int perr;
    logic ex;
    logic [7:0] ecnt;
    L = (len == 0) ? 1 : ((len > 8) ? 8 : int'(len));
    nm = 0;
    perr = 0;
    start = 1; cfg_pat = pat; cfg_len = len;
    @(posedge clk); #1;
    start = 0;
    cfg_pat = 8'($urandom);
    cfg_len = 4'($urandom);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL %s start: in_ready=%b busy=%b want 1 1",
               name, in_ready, busy);
    else passed++;
    for (int w = 0; w < wq.size(); w++) begin
      int t;
      logic [7:0] wd;
      t = 0;
      wd = wq[w];
      in_valid = 1; in_data = wd; in_last = (w == wq.size() - 1);
      while (in_ready !== 1'b1 && t < 20) begin
        @(posedge clk); #1; t++;
      end
      if (t >= 20) begin
        checks++;
        $display("FAIL %s accept timeout: in_ready=%b want 1",
                 name, in_ready);
        in_valid = 0; start = 0;
        return;
      end
      @(posedge clk); #1;
      in_valid = hold;
      in_data = 8'($urandom);
      in_last = 1'($urandom);
      start = hold;
      for (int j = 0; j < 8; j++) begin
        hist.push_back(wd[7-j]);
        ex = 1'b0;
        if (hist.size() >= L) begin
          ex = 1'b1;
          for (int i = 0; i < L; i++)
            if (hist[hist.size()-1-i] != pat[i]) ex = 1'b0;
        end
        if (ex) nm++;
        @(posedge clk); #1;
        if (match_pulse !== ex) perr++;
        if (j < 7 && (in_ready !== 1'b0 || done !== 1'b0
                      || busy !== 1'b1)) perr++;
      end
      start = 0;
      if (done !== (w == wq.size() - 1)) perr++;
    end
    in_valid = 0; in_last = 0;
    ecnt = (nm > 255) ? 8'd255 : 8'(nm);
    checks++;
    if (perr != 0)
      $display("FAIL %s pulses: %0d cycle errors, want 0", name, perr);
    else passed++;
    checks++;
    if (match_cnt !== ecnt || done !== 1'b1)
      $display("FAIL %s count: cnt=%0d done=%b want %0d 1",
               name, match_cnt, done, ecnt);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0
        || match_cnt !== ecnt)
      $display("FAIL %s idle: done=%b busy=%b rdy=%b cnt=%0d want 0 0 0 %0d",
               name, done, busy, in_ready, match_cnt, ecnt);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; cfg_pat = 0; cfg_len = 0;
    in_valid = 0; in_data = 0; in_last = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL rst in_ready: %b want 0", in_ready);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL rst busy: %b want 0", busy);
    else passed++;
    checks++;
    if (match_pulse !== 1'b0) $display("FAIL rst pulse: %b want 0", match_pulse);
    else passed++;
    checks++;
    if (done !== 1'b0) $display("FAIL rst done: %b want 0", done);
    else passed++;
    checks++;
    if (match_cnt !== 8'd0) $display("FAIL rst cnt: %0d want 0", match_cnt);
    else passed++;
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_word();
    wq = '{8'hA5};
    run_frame(8'b101, 4'd3, 0, "a5");
  endtask

  task automatic test_boundary();
    wq = '{8'h01, 8'h40};
    run_frame(8'b101, 4'd3, 0, "boundary");
  endtask

  task automatic test_overlap();
    wq = '{8'hF0};
    run_frame(8'b11, 4'd2, 0, "overlap");
    wq = '{8'h80};
    run_frame(8'b1, 4'd0, 0, "len0");
    wq = '{8'hC3};
    run_frame(8'hC3, 4'd12, 0, "lenbig");
  endtask

  task automatic test_saturation();
    wq = {};
    for (int i = 0; i < 32; i++) wq.push_back(8'hFF);
    run_frame(8'b1, 4'd1, 0, "sat");
  endtask

  task automatic test_back_to_back();
    wq = '{8'h5A, 8'hB6, 8'h6D};
    run_frame(8'b0110, 4'd4, 1, "stall");
  endtask

  task automatic test_reset_mid();
    start = 1; cfg_pat = 8'b1; cfg_len = 4'd1;
    @(posedge clk); #1;
    start = 0;
    in_valid = 1; in_data = 8'hFF; in_last = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (match_cnt !== 8'd3)
      $display("FAIL midrst pre-count: %0d want 3", match_cnt);
    else passed++;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if (busy !== 0 || in_ready !== 0 || done !== 0
        || match_pulse !== 0 || match_cnt !== 0)
      $display("FAIL midrst outs: busy=%b rdy=%b done=%b mp=%b cnt=%0d want zeros",
               busy, in_ready, done, match_pulse, match_cnt);
    else passed++;
    repeat (10) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL midrst nodone: done=%b busy=%b want 0 0", done, busy);
      else passed++;
    end
    wq = '{8'h0F};
    run_frame(8'b1, 4'd1, 0, "after_rst");
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      int nw;
      nw = $urandom_range(1, 4);
      wq = {};
      for (int i = 0; i < nw; i++) wq.push_back(8'($urandom));
      run_frame(8'($urandom), 4'($urandom), bit'($urandom), "rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_boundary();
    test_overlap();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
